softmax_div_seq: RTL and testbench
==================================

SOFTMAX_DIV_SEQ -- requirements
Module: softmax_div_seq

Interface
REQ-001 SHALL have parameter D_W, default 32: width of the data path, sum and divider operands.
REQ-002 SHALL have parameter N, default 16: number of elements per softmax row (N >= 2).
REQ-003 SHALL have parameter OUT_SHIFT, default 8: fixed-point scale applied to the dividend.
REQ-004 SHALL have port clk  input  1  the single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port enable  input  1  global advance; when low, all state holds.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_data  input  D_W  unsigned exponent-approximation value.
REQ-009 SHALL have port in_ready  output  1  row buffer is accepting input.
REQ-010 SHALL have port div_in_valid  output  1  request to the divider.
REQ-011 SHALL have port div_dividend  output  D_W  dividend to the divider.
REQ-012 SHALL have port div_divisor  output  D_W  divisor to the divider, equal to the row sum.
REQ-013 SHALL have port div_quotient  input  D_W  divider result.
REQ-014 SHALL have port div_out_valid  input  1  divider result valid.
REQ-015 SHALL have port out_valid  output  1  one-cycle pulse: out_data is valid.
REQ-016 SHALL have port out_data  output  D_W  normalised element.
REQ-017 SHALL have port out_last  output  1  qualifies the final element of a row.

Function
REQ-018 SHALL implement the states LOAD, ISSUE, WAIT and EMIT; all transitions and register updates are gated by enable.
REQ-019 LOAD: in_ready = enable; on in_valid&enable, write in_data to buf[wr_idx], add it to sum and increment wr_idx; after the Nth accept, go to ISSUE with rd_idx=0.
REQ-020 ISSUE, sum!=0: assert div_in_valid for exactly one enabled cycle with div_dividend = buf[rd_idx]<<OUT_SHIFT (truncated to D_W) and div_divisor = sum, then go to WAIT.
REQ-021 ISSUE, sum==0: do not assert div_in_valid; go to EMIT with a result of 0 (divide-by-zero bypass).
REQ-022 WAIT: on div_out_valid, latch div_quotient and go to EMIT; otherwise hold.
REQ-023 EMIT: pulse out_valid for one cycle with out_data = the latched result, and out_last = (rd_idx==N-1).
REQ-024 From EMIT, go to ISSUE with rd_idx+1 if rd_idx<N-1; otherwise clear sum and wr_idx and go to LOAD.
REQ-025 in_ready SHALL be 0 outside LOAD; in_valid outside LOAD is ignored and not stored.
REQ-026 div_dividend and div_divisor SHALL hold their values while in WAIT.
REQ-027 Latency from the Nth accept to the first out_valid SHALL be 2 cycles plus the divider latency (ISSUE, divider, EMIT); the sum==0 path takes 2 cycles per element.
REQ-028 div_out_valid outside WAIT SHALL be ignored.

Reset
REQ-029 On rst, the state SHALL go to LOAD; sum, wr_idx and rd_idx go to 0; in_ready, div_in_valid, out_valid and out_last go to 0; out_data, div_dividend and div_divisor go to 0.
REQ-030 Reset mid-row SHALL discard any partial row and any outstanding divider request; the first row after release starts cleanly.
REQ-031 buf contents SHALL not be reset.

Configuration
REQ-032 With SOFTMAX_SUM_SAT_EN defined, sum accumulation SHALL saturate at 2^D_W-1; without it, sum wraps modulo 2^D_W.

Structure
REQ-033 Package softmax_pkg SHALL hold the state enum type and the default constants for D_W, N and OUT_SHIFT.
REQ-034 The row storage SHALL be a sub-module softmax_row_buf: N x D_W registers, one write port and one combinational read port.

Verification
REQ-035 Use N=4, D_W=32 and OUT_SHIFT=8, with the divider model returning floor(dividend/divisor). Input 1,1,1,1 -> div_divisor=4 and div_dividend=256, giving out_data 64,64,64,64, with out_last only on the 4th.
REQ-036 Input 0,0,0,0 -> div_in_valid never asserted; four out_valid pulses with out_data 0 at 2-cycle spacing.
REQ-037 Input 0xFFFFFFF0 twice, then 0, 0: with SOFTMAX_SUM_SAT_EN defined, div_divisor=0xFFFFFFFF; without it, div_divisor=0xFFFFFFE0.
REQ-038 Input 1,1,1,1 with enable low for 5 cycles during WAIT -> no state change and no outputs during the stall; results are identical to REQ-035.
REQ-039 Input 2,2,2,2 with rst pulsed during the second WAIT -> out_valid goes to 0 immediately; next row 1,3,0,4 (sum 8) -> out_data 32,96,0,128.
REQ-040 Hold in_valid=1 with in_data=7 throughout the ISSUE/WAIT/EMIT phases -> in_ready stays 0 and nothing is stored; the next row accepts only after out_last.

Source files
------------

// File: rtl/softmax_pkg.sv
// softmax_pkg: shared state type, default constants and small helpers for the
// softmax normalisation sequencer (softmax_div_seq) and its row buffer.
package softmax_pkg;

    // Default data path width, row length and dividend scale
    localparam int SM_D_W       = 32;
    localparam int SM_N         = 16;
    localparam int SM_OUT_SHIFT = 8;

    // Sequencer phases: fill the row, request a divide, wait for it, present it
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } sm_state_t;

    // Index width for an N-entry row, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/softmax_row_buf.sv
// softmax_row_buf: N x D_W register file holding one softmax row.
// One synchronous write port and one combinational read port. Contents are
// deliberately not reset; the sequencer always rewrites every entry of a row
// before it reads any of them back.
module softmax_row_buf
    import softmax_pkg::*;
#(
    parameter int D_W   = SM_D_W,
    parameter int N     = SM_N,
    parameter int IDX_W = idx_width(SM_N)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [D_W-1:0]   wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [D_W-1:0]   rdata
);

    logic [D_W-1:0] mem [N];

    // Store one element per write strobe; no reset so the array maps to plain flops/RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/softmax_div_seq.sv
// softmax_div_seq: collects a row of N exponent approximations, accumulates
// their sum, then walks the row issuing one divide per element
// (element << OUT_SHIFT) / sum to an external divider and emitting each
// quotient with out_last on the final element. A zero row sum bypasses the
// divider and emits zeros.
//
// Build option: define SOFTMAX_SUM_SAT_EN to make the row sum saturate at
// all-ones instead of wrapping modulo 2^D_W.
module softmax_div_seq
    import softmax_pkg::*;
#(
    parameter int D_W       = SM_D_W,
    parameter int N         = SM_N,
    parameter int OUT_SHIFT = SM_OUT_SHIFT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           in_valid,
    input  logic [D_W-1:0] in_data,
    output logic           in_ready,
    output logic           div_in_valid,
    output logic [D_W-1:0] div_dividend,
    output logic [D_W-1:0] div_divisor,
    input  logic [D_W-1:0] div_quotient,
    input  logic           div_out_valid,
    output logic           out_valid,
    output logic [D_W-1:0] out_data,
    output logic           out_last
);

    localparam int               IDX_W    = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    sm_state_t        state;
    sm_state_t        state_next;
    logic [D_W-1:0]   sum;
    logic [D_W-1:0]   sum_add;
    logic [D_W-1:0]   result;
    logic [D_W-1:0]   rd_data;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             accept;
    logic             last_accept;
    logic             sum_zero;
    logic             last_elem;

    assign accept      = enable && in_valid && (state == LOAD);
    assign last_accept = accept && (wr_idx == LAST_IDX);
    assign sum_zero    = (sum == '0);
    assign last_elem   = (rd_idx == LAST_IDX);

`ifdef SOFTMAX_SUM_SAT_EN
    logic [D_W:0] sum_wide;

    // Saturating accumulate: a carry out of the top bit pins the sum at all-ones
    always_comb begin
        sum_wide = {1'b0, sum} + {1'b0, in_data};
        sum_add  = sum_wide[D_W] ? '1 : sum_wide[D_W-1:0];
    end
`else
    // Wrapping accumulate: the carry out is simply dropped
    assign sum_add = sum + in_data;
`endif

    softmax_row_buf #(
        .D_W   (D_W),
        .N     (N),
        .IDX_W (IDX_W)
    ) u_row_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_idx),
        .wdata (in_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    // State register; a low enable freezes the sequencer in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Next-state decode: fill, then issue/wait/emit once per element, then refill
    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                if (last_accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = sum_zero ? EMIT : WAIT;
            end
            WAIT: begin
                if (div_out_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                state_next = last_elem ? LOAD : ISSUE;
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Datapath registers: row sum, write/read indices and the latched quotient
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum    <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            result <= '0;
        end else if (enable) begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        sum <= sum_add;
                        if (last_accept) begin
                            wr_idx <= '0;
                            rd_idx <= '0;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (sum_zero) begin
                        result <= '0;
                    end
                end
                WAIT: begin
                    if (div_out_valid) begin
                        result <= div_quotient;
                    end
                end
                EMIT: begin
                    if (last_elem) begin
                        sum    <= '0;
                        wr_idx <= '0;
                        rd_idx <= '0;
                    end else begin
                        rd_idx <= rd_idx + IDX_W'(1);
                    end
                end
                default: begin
                    sum <= sum;
                end
            endcase
        end
    end

    // Output decode; divider operands are held steady for the whole ISSUE/WAIT span
    always_comb begin
        in_ready     = enable && !rst && (state == LOAD);
        div_in_valid = enable && (state == ISSUE) && !sum_zero;
        div_dividend = '0;
        div_divisor  = '0;
        if (((state == ISSUE) && !sum_zero) || (state == WAIT)) begin
            div_dividend = rd_data << OUT_SHIFT;
            div_divisor  = sum;
        end
        out_valid = enable && (state == EMIT);
        out_last  = enable && (state == EMIT) && last_elem;
        out_data  = result;
    end

endmodule

// File: tb/tb_softmax_div_seq.sv
// tb_softmax_div_seq: scoreboard bench for softmax_div_seq with N=4, D_W=32,
// OUT_SHIFT=8. A divider responder returns floor(dividend/divisor) after a
// programmable latency. Expected divider requests and outputs are computed
// from whole-row arithmetic and queued; a negedge monitor pops and compares.
module tb_softmax_div_seq;

    localparam int D_W       = 32;
    localparam int N         = 4;
    localparam int OUT_SHIFT = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           in_valid;
    logic [D_W-1:0] in_data;
    logic           in_ready;
    logic           div_in_valid;
    logic [D_W-1:0] div_dividend;
    logic [D_W-1:0] div_divisor;
    logic [D_W-1:0] div_quotient;
    logic           div_out_valid;
    logic           out_valid;
    logic [D_W-1:0] out_data;
    logic           out_last;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  gap;
    } exp_t;

    typedef struct packed {
        logic [31:0] dividend;
        logic [31:0] divisor;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];

    int n_checks     = 0;
    int n_pass       = 0;
    int req_seen     = 0;
    int rows_loaded  = 0;
    int rows_emitted = 0;
    int cycle        = 0;
    int last_out_cyc = 0;
    int div_lat      = 0;

    softmax_div_seq #(
        .D_W       (D_W),
        .N         (N),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .div_in_valid  (div_in_valid),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_out_valid (div_out_valid),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Divider responder: answers each request after div_lat WAIT cycles (random 1..4 when 0)
    int          rsp_cnt;
    logic        rsp_pend;
    logic        rsp_taken;
    logic [31:0] rsp_q;
    always @(negedge clk) begin
        if (rst) begin
            div_out_valid = 1'b0;
            div_quotient  = '0;
            rsp_pend      = 1'b0;
            rsp_taken     = 1'b0;
            rsp_cnt       = 0;
        end else begin
            if (rsp_taken) begin
                div_out_valid = 1'b0;
                div_quotient  = $urandom;
            end
            if (div_in_valid && enable) begin
                rsp_pend = 1'b1;
                rsp_cnt  = (div_lat == 0) ? int'($urandom_range(1, 4)) : div_lat;
                rsp_q    = (div_divisor != 0) ? div_dividend / div_divisor : 32'd0;
            end else if (rsp_pend) begin
                rsp_cnt--;
                if (rsp_cnt <= 0) begin
                    rsp_pend      = 1'b0;
                    div_out_valid = 1'b1;
                    div_quotient  = rsp_q;
                end
            end
            rsp_taken = div_out_valid && enable;
        end
    end

    // Monitor: compare divider requests and emitted elements against the queues
    always @(negedge clk) begin
        exp_t e;
        req_t r;
        if (!rst) begin
            if (!enable) begin
                checkOutput("stall_quiet", {61'd0, out_valid, div_in_valid, in_ready}, 64'd0);
            end
            if (rows_loaded != rows_emitted) begin
                checkOutput("busy_in_ready", {63'd0, in_ready}, 64'd0);
            end
            if (div_in_valid) begin
                req_seen++;
                if (req_q.size() == 0) begin
                    checkOutput("unexpected_div_req", 64'd1, 64'd0);
                end else begin
                    r = req_q.pop_front();
                    checkOutput("div_dividend", {32'd0, div_dividend}, {32'd0, r.dividend});
                    checkOutput("div_divisor", {32'd0, div_divisor}, {32'd0, r.divisor});
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", {32'd0, out_data}, {32'd0, e.data});
                    checkOutput("out_last", {63'd0, out_last}, {63'd0, e.last});
                    if (e.gap != 0) begin
                        checkOutput("emit_spacing", 64'(cycle - last_out_cyc), {60'd0, e.gap});
                    end
                end
                last_out_cyc = cycle;
                if (out_last) rows_emitted++;
            end
        end
    end

    task automatic sendElem(input logic [31:0] v);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        checkOutput("accepted", {63'd0, ok}, 64'd1);
    endtask

    // Queue the row's expected behaviour from plain arithmetic, then drive it
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d, input bit hold7);
        logic [31:0]     v[4];
        longint unsigned s;
        longint unsigned prod;
        logic [31:0]     sum32;
        exp_t            e;
        req_t            r;
        v = '{a, b, c, d};
        s = 0;
        for (int i = 0; i < N; i++) s += longint'(v[i]);
`ifdef SOFTMAX_SUM_SAT_EN
        if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
`else
        s = s % 64'h1_0000_0000;
`endif
        sum32 = s[31:0];
        for (int i = 0; i < N; i++) begin
            prod       = longint'(v[i]) * (64'd1 << OUT_SHIFT);
            r.dividend = prod[31:0];
            r.divisor  = sum32;
            e.data     = (sum32 != 0) ? r.dividend / sum32 : 32'd0;
            e.last     = (i == N - 1);
            e.gap      = (sum32 == 0 && i > 0) ? 4'd2 : 4'd0;
            if (sum32 != 0) req_q.push_back(r);
            exp_q.push_back(e);
        end
        for (int i = 0; i < N; i++) sendElem(v[i]);
        rows_loaded++;
        if (hold7) begin
            in_data = 32'd7;
            for (int k = 0; k < 400 && rows_loaded != rows_emitted; k++) begin
                @(negedge clk);
                #1;
            end
            checkOutput("hold_row_done", 64'(rows_emitted), 64'(rows_loaded));
            @(posedge clk);
            #1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic waitIdle();
        for (int k = 0; k < 1000 && (exp_q.size() != 0 || rows_loaded != rows_emitted); k++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("idle_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic waitReq(input int target);
        for (int k = 0; k < 200 && req_seen < target; k++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("req_reached", 64'(req_seen >= target), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          base;
        logic [31:0] rv[4];
        rst      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_out_last", {63'd0, out_last}, 64'd0);
        checkOutput("rst_div_in_valid", {63'd0, div_in_valid}, 64'd0);
        checkOutput("rst_out_data", {32'd0, out_data}, 64'd0);
        checkOutput("rst_div_dividend", {32'd0, div_dividend}, 64'd0);
        checkOutput("rst_div_divisor", {32'd0, div_divisor}, 64'd0);
        enable = 1'b1;
        #1;
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("load_in_ready", {63'd0, in_ready}, 64'd1);

        $display("[TB] uniform row");
        applyStimulus(32'd1, 32'd1, 32'd1, 32'd1, 0);
        waitIdle();

        $display("[TB] zero-sum row");
        applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 0);
        waitIdle();

        $display("[TB] sum overflow row");
        applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd0, 32'd0, 0);
        waitIdle();

        $display("[TB] enable stall during WAIT");
        div_lat = 3;
        base    = req_seen;
        applyStimulus(32'd1, 32'd1, 32'd1, 32'd1, 0);
        waitReq(base + 1);
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b1;
        waitIdle();

        $display("[TB] reset during second WAIT");
        div_lat = 4;
        base    = req_seen;
        applyStimulus(32'd2, 32'd2, 32'd2, 32'd2, 0);
        waitReq(base + 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midrst_div_in_valid", {63'd0, div_in_valid}, 64'd0);
        checkOutput("midrst_div_divisor", {32'd0, div_divisor}, 64'd0);
        exp_q.delete();
        req_q.delete();
        rows_loaded = rows_emitted;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        div_lat = 0;
        applyStimulus(32'd1, 32'd3, 32'd0, 32'd4, 0);
        waitIdle();

        $display("[TB] in_valid held high while busy");
        applyStimulus(32'd5, 32'd10, 32'd15, 32'd20, 1);
        applyStimulus(32'd9, 32'd1, 32'd30, 32'd60, 0);
        waitIdle();

        $display("[TB] random rows");
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                rv[i] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 5000);
            end
            applyStimulus(rv[0], rv[1], rv[2], rv[3], 0);
        end
        waitIdle();

        checkOutput("req_q_drained", 64'(req_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
